// File: rtl/flipflop_en_pkg.sv
// flipflop_en_pkg
//   Shared constants and helpers for the flipflop_en register family.
//   FF_DEFAULT_WIDTH : default register width
//   FF_MAX_WIDTH     : widest supported register
//   FF_DEFAULT_RESET : default reset value (sized to FF_MAX_WIDTH)
//   ff_width_ok()    : legality check for the WIDTH parameter
package flipflop_en_pkg;

   localparam int unsigned FF_DEFAULT_WIDTH = 32'd8;
   localparam int unsigned FF_MAX_WIDTH     = 32'd64;
   localparam logic [FF_MAX_WIDTH-1:0] FF_DEFAULT_RESET = 64'd0;

   // True when w is a supported register width.
   function automatic bit ff_width_ok(input int unsigned w);
      return (w >= 32'd1) && (w <= FF_MAX_WIDTH);
   endfunction

endpackage

// File: rtl/flipflop_en_parity.sv
// flipflop_en_parity
//   Combinational even-parity generator (XOR-reduce) of a WIDTH-bit vector.
//   Only instantiated when FLIPFLOP_EN_PARITY_EN is defined.
//   Ports:
//     vec    in  WIDTH  vector to reduce
//     parity out 1      XOR of all bits of vec
module flipflop_en_parity
   import flipflop_en_pkg::*;
#(
   parameter int unsigned WIDTH = FF_DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] vec,
   output logic             parity
);

   // Even-parity bit of an arbitrary WIDTH vector.
   function automatic logic xor_reduce(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction

   // Pure reduction; no state.
   always_comb begin
      parity = xor_reduce(vec);
   end

endmodule

// File: rtl/flipflop_en.sv
// flipflop_en
//   WIDTH-bit register with synchronous load enable and synchronous
//   active-low reset. Priority per rising edge: reset, then en, then hold.
//   q comes straight from flops; there is no path from d/en to q.
//   Optional feature macro: FLIPFLOP_EN_PARITY_EN
//     Adds a stored parity bit for q and a registered parity_err output
//     that flags a q/parity disagreement one cycle after it appears.
//   Ports:
//     clk        in  1      rising-edge clock
//     reset      in  1      synchronous reset, 0 = asserted
//     en         in  1      load enable, active-high
//     d          in  WIDTH  data to capture
//     q          out WIDTH  registered state
//     parity_err out 1      (FLIPFLOP_EN_PARITY_EN only) parity mismatch flag
module flipflop_en
   import flipflop_en_pkg::*;
#(
   parameter int unsigned               WIDTH       = FF_DEFAULT_WIDTH,
   parameter logic [FF_MAX_WIDTH-1:0]   RESET_VALUE = FF_DEFAULT_RESET
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
`ifdef FLIPFLOP_EN_PARITY_EN
   ,
   output logic             parity_err
`endif
);

   // Reject unsupported widths while elaborating.
   if (!ff_width_ok(WIDTH)) begin : g_width_check
      $error("flipflop_en: WIDTH must be within 1..64");
   end

   localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

   logic [WIDTH-1:0] q_r;

   // Main state register. The ternary (rather than if/else on en) lets an
   // unknown en propagate X into q in simulation instead of silently holding.
   always_ff @(posedge clk) begin
      if (!reset) begin
         q_r <= RST_VAL;
      end else begin
         q_r <= en ? d : q_r;
      end
   end

   assign q = q_r;

`ifdef FLIPFLOP_EN_PARITY_EN
   localparam logic RST_PAR = ^RST_VAL;

   logic par_d_s;
   logic par_q_s;
   logic p_r;
   logic parity_err_r;

   flipflop_en_parity #(.WIDTH(WIDTH)) u_par_d (
      .vec    (d),
      .parity (par_d_s)
   );

   flipflop_en_parity #(.WIDTH(WIDTH)) u_par_q (
      .vec    (q_r),
      .parity (par_q_s)
   );

   // Stored parity tracks exactly the loads of q_r.
   always_ff @(posedge clk) begin
      if (!reset) begin
         p_r <= RST_PAR;
      end else begin
         p_r <= en ? par_d_s : p_r;
      end
   end

   // Registered mismatch flag: reports the disagreement seen on the
   // previous cycle, so it never glitches on q changes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         parity_err_r <= 1'b0;
      end else begin
         parity_err_r <= (par_q_s != p_r);
      end
   end

   assign parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_flipflop_en.sv
module tb_flipflop_en;

   logic       clk;
   logic       reset2, en2;
   logic [1:0] d2, q2;
   logic       reset8, en8;
   logic [7:0] d8, q8;
`ifdef FLIPFLOP_EN_PARITY_EN
   logic       perr2, perr8;
`endif

   int tests_run;
   int tests_failed;

   flipflop_en #(.WIDTH(2)) dut2 (
      .clk   (clk),
      .reset (reset2),
      .en    (en2),
      .d     (d2),
      .q     (q2)
`ifdef FLIPFLOP_EN_PARITY_EN
      ,
      .parity_err (perr2)
`endif
   );

   flipflop_en #(.WIDTH(8), .RESET_VALUE(64'hA5)) dut8 (
      .clk   (clk),
      .reset (reset8),
      .en    (en8),
      .d     (d8),
      .q     (q8)
`ifdef FLIPFLOP_EN_PARITY_EN
      ,
      .parity_err (perr8)
`endif
   );

   // 40 ns clock period
   initial clk = 1'b0;
   always #20 clk = ~clk;

   typedef struct {
      bit         w8;
      logic       rst;
      logic       en;
      logic [7:0] d;
      logic [7:0] exp;
      string      name;
   } vec_t;

   typedef struct {
      string      name;
      logic [7:0] exp;
      bit         w8;
   } sb_t;

   sb_t  sbq[$];
   vec_t vt[16];

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_pop();
      sb_t e;
      logic [7:0] act;
      if (sbq.size() == 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL scoreboard: got empty queue expected entry");
      end else begin
         e = sbq.pop_front();
         act = e.w8 ? q8 : {6'b000000, q2};
         check(e.name, act, e.exp);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      if (v.w8) begin
         reset8 = v.rst; en8 = v.en; d8 = v.d;
      end else begin
         reset2 = v.rst; en2 = v.en; d2 = v.d[1:0];
      end
      sbq.push_back('{v.name, v.exp, v.w8});
      @(posedge clk);
      #1;
      check_pop();
   endtask

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset2 = 1'b0; en2 = 1'b0; d2 = 2'd2;
      reset8 = 1'b0; en8 = 1'b0; d8 = 8'h00;

      // WIDTH=2 vectors
      vt[0]  = '{1'b0, 1'b0, 1'b0, 8'h2, 8'h0, "w2_reset_e1"};
      vt[1]  = '{1'b0, 1'b0, 1'b0, 8'h2, 8'h0, "w2_reset_e2"};
      vt[2]  = '{1'b0, 1'b0, 1'b0, 8'h2, 8'h0, "w2_reset_e3"};
      vt[3]  = '{1'b0, 1'b1, 1'b1, 8'h2, 8'h2, "w2_load_2"};
      vt[4]  = '{1'b0, 1'b1, 1'b1, 8'h1, 8'h1, "w2_load_1"};
      vt[5]  = '{1'b0, 1'b1, 1'b0, 8'h0, 8'h1, "w2_hold_d0"};
      vt[6]  = '{1'b0, 1'b1, 1'b0, 8'h2, 8'h1, "w2_hold_d2"};
      vt[7]  = '{1'b0, 1'b1, 1'b0, 8'h3, 8'h1, "w2_hold_d3"};
      vt[8]  = '{1'b0, 1'b1, 1'b0, 8'h0, 8'h1, "w2_hold_d0b"};
      vt[9]  = '{1'b0, 1'b0, 1'b1, 8'h3, 8'h0, "w2_reset_beats_en"};
      vt[10] = '{1'b0, 1'b1, 1'b1, 8'h3, 8'h3, "w2_load_3"};
      // WIDTH=8, RESET_VALUE=A5 vectors
      vt[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hA5, "w8_reset"};
      vt[12] = '{1'b1, 1'b1, 1'b1, 8'h3C, 8'h3C, "w8_load_3c"};
      vt[13] = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h3C, "w8_hold"};
      vt[14] = '{1'b1, 1'b0, 1'b1, 8'hFF, 8'hA5, "w8_reset_beats_en"};
      vt[15] = '{1'b1, 1'b1, 1'b1, 8'h3C, 8'h3C, "w8_reload_3c"};

      for (int i = 0; i < 16; i++) begin
         apply(vt[i]);
      end

      // Reset pulsed low only between edges: q (3) must be unaffected.
      @(negedge clk);
      reset2 = 1'b1; en2 = 1'b0; d2 = 2'd0;
      sbq.push_back('{"w2_midcycle_reset", 8'h03, 1'b0});
      @(posedge clk);
      #5  reset2 = 1'b0;
      #10 reset2 = 1'b1;
      @(posedge clk);
      #1;
      check_pop();

`ifdef FLIPFLOP_EN_PARITY_EN
      // dut8 holds 3C with en=0; flip bit0 of the stored value.
      check("w2_perr_idle", {7'd0, perr2}, 8'h00);
      check("w8_perr_clean", {7'd0, perr8}, 8'h00);
      @(negedge clk);
      en8 = 1'b0; reset8 = 1'b1;
      force dut8.q_r = 8'h3D;
      #1;
      release dut8.q_r;
      @(posedge clk);
      #1;
      check("w8_corrupt_q", q8, 8'h3D);
      check("w8_perr_set", {7'd0, perr8}, 8'h01);
      @(negedge clk);
      reset8 = 1'b0;
      @(posedge clk);
      #1;
      check("w8_perr_in_reset", {7'd0, perr8}, 8'h00);
      check("w8_q_in_reset", q8, 8'hA5);
      @(negedge clk);
      reset8 = 1'b1;
      @(posedge clk);
      #1;
      check("w8_perr_after_reset", {7'd0, perr8}, 8'h00);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/flipflop_en.md
Name: flipflop_en

Overview:
- Parameterized WIDTH-bit register with synchronous load enable.
- Generic state-holding element of the microprocessor datapath: PC, pipeline and flag registers, instruction latches.
- Single clock domain; synchronous active-low reset.
- No combinational path from inputs to q.

Parameters:
- WIDTH, 8, data width in bits; legal range 1..64. Instantiated as 2 for flag/control storage.
- RESET_VALUE, 0, value loaded into q on reset; truncated to WIDTH bits.

Ports:
- clk  input  1  rising-edge clock, sole clock.
- reset  input  1  synchronous reset, active-low. The codebase name is "reset"; 0 means reset asserted.
- en  input  1  load enable, active-high.
- d  input  WIDTH  data to capture.
- q  output  WIDTH  registered state.

Behaviour:
- All state updates on the rising edge of clk only.
- Priority at each edge: reset first, then en, then hold.
  - reset==0: q <= RESET_VALUE[WIDTH-1:0], regardless of en and d.
  - reset==1 and en==1: q <= d.
  - reset==1 and en==0: q holds its previous value.
- Latency: d is visible on q one clock edge after the capturing edge. No combinational bypass.
- reset is sampled only at clock edges. Asserting or deasserting it between edges has no effect until the next rising edge.
- Reset asserted with en==1 on the same edge: reset wins and d is discarded.
- Power-up, before the first reset edge: q is undefined (X in simulation). Consumers must apply reset for at least one edge.
- X or Z on en while reset==1: simulation propagates X to q. No masking is required.
- WIDTH==1 must be supported. All bits load in parallel; there are no per-bit enables.
- Outputs are driven directly from flops; no glitching logic on q.

Optional Feature:
- Macro: FLIPFLOP_EN_PARITY_EN.
- When defined:
  - Adds an internal stored even-parity bit p, computed as the XOR of d and loaded whenever d loads.
  - Reset sets p to the parity of RESET_VALUE.
  - Adds output port parity_err, 1 bit, registered. It is asserted the cycle after XOR(q) != p is observed.
  - parity_err is 0 during and after reset.
  - Enables detection of SEU or forced corruption of q in simulation.
- When undefined:
  - The parity_err port and parity logic are absent.
  - The port list is exactly clk, reset, en, d, q.

Decomposition:
- Shared package flipflop_en_pkg holds:
  - constant FF_DEFAULT_WIDTH = 8
  - constant FF_MAX_WIDTH = 64
  - constant FF_DEFAULT_RESET = 0
  - a width-check function, used for an elaboration-time assertion that 1 <= WIDTH <= 64.
- Natural sub-module: flipflop_en_parity, a combinational XOR-reduce of a WIDTH vector. It is used only under FLIPFLOP_EN_PARITY_EN.
- Top-level flop logic stays in flipflop_en.

Test Plan:
- WIDTH=2, 40 ns clock period.
  - reset=0, en=0, d=2 held for 3 edges -> q==0 after the first edge; q stays 0.
  - reset=1, en=1, d=2 -> q==2 one edge later. Then d=1, en=1 -> q==1 on the next edge.
  - q==1, en=0, d cycles 0,2,3 over 4 edges -> q remains 1 throughout.
  - reset=0 and en=1 with d=3 on the same edge -> q==0; d is ignored.
  - reset pulsed low between edges only, high at every rising edge -> q unchanged.
- WIDTH=8, RESET_VALUE=8'hA5:
  - reset -> q==8'hA5.
  - load 8'h3C -> q==8'h3C.
  - with FLIPFLOP_EN_PARITY_EN: force q bit0 flipped -> parity_err==1 on the next edge, and 0 after the next reset.
